// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-write, dual-read register file with bypass and sequential clear engine
// Optional: define ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              ready,
  input  logic              W_En_A,
  input  logic [ADDR_W-1:0] W_Addr_A,
  input  logic [DATA_W-1:0] W_Data_A,
  input  logic              W_En_B,
  input  logic [ADDR_W-1:0] W_Addr_B,
  input  logic [DATA_W-1:0] W_Data_B,
  input  logic [ADDR_W-1:0] R_Addr_A,
  output logic [DATA_W-1:0] R_Data_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic [DATA_W-1:0] R_Data_B,
  output logic              wr_collision
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              coll_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic in_run, clr_last, same_addr, wr_ok, we_a, we_b, fwd_a_ok, fwd_b_ok;

  assign in_run    = (state == S_RUN);
  assign clr_last  = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign same_addr = (W_Addr_A == W_Addr_B);
  assign wr_ok     = in_run & ~clr_req;
  assign fwd_a_ok  = wr_ok & W_En_A;
  assign fwd_b_ok  = wr_ok & W_En_B;
  // Port B wins a same-address collision, so port A is simply suppressed.
  assign we_a = fwd_a_ok & ~(W_En_B & same_addr) & ~(ZERO_REG && (W_Addr_A == '0));
  assign we_b = fwd_b_ok & ~(ZERO_REG && (W_Addr_B == '0));
  assign ready = in_run;

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    coll_nxt    = 1'b0;
    case (state)
      S_INIT: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_last) begin
          state_nxt   = S_RUN;
          clr_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        if (clr_req) begin
          state_nxt   = S_INIT;
          clr_cnt_nxt = '0;
        end else begin
          coll_nxt = W_En_A & W_En_B & same_addr;
        end
      end
      default: begin
        state_nxt   = S_INIT;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_INIT;
      clr_cnt      <= '0;
      wr_collision <= 1'b0;
    end else begin
      state        <= state_nxt;
      clr_cnt      <= clr_cnt_nxt;
      wr_collision <= coll_nxt;
    end
  end

  // No reset on the array: while reset is held the engine just rewrites entry 0.
  always_ff @(posedge clk) begin
    if (!in_run) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (we_a) mem[W_Addr_A] <= W_Data_A;
      if (we_b) mem[W_Addr_B] <= W_Data_B;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = mem[addr];
    if (!in_run)                                           v = '0;
    else if (ZERO_REG && (addr == '0))                     v = '0;
    else if ((BYPASS != 0) && fwd_b_ok && (W_Addr_B == addr)) v = W_Data_B;
    else if ((BYPASS != 0) && fwd_a_ok && (W_Addr_A == addr)) v = W_Data_A;
    return v;
  endfunction

  always_comb begin
    R_Data_A = rd(R_Addr_A);
    R_Data_B = rd(R_Addr_B);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, BYPASS=1 and BYPASS=0 instances side by side
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, clr_req;
  logic w_en_a, w_en_b;
  logic [AW-1:0] w_addr_a, w_addr_b, r_addr_a, r_addr_b;
  logic [DW-1:0] w_data_a, w_data_b;
  logic rdy1, rdy0, coll1, coll0;
  logic [DW-1:0] rda1, rdb1, rda0, rdb0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [DW-1:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .clr_req(clr_req), .ready(rdy1),
    .W_En_A(w_en_a), .W_Addr_A(w_addr_a), .W_Data_A(w_data_a),
    .W_En_B(w_en_b), .W_Addr_B(w_addr_b), .W_Data_B(w_data_b),
    .R_Addr_A(r_addr_a), .R_Data_A(rda1), .R_Addr_B(r_addr_b), .R_Data_B(rdb1),
    .wr_collision(coll1)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .clr_req(clr_req), .ready(rdy0),
    .W_En_A(w_en_a), .W_Addr_A(w_addr_a), .W_Data_A(w_data_a),
    .W_En_B(w_en_b), .W_Addr_B(w_addr_b), .W_Data_B(w_data_b),
    .R_Addr_A(r_addr_a), .R_Data_A(rda0), .R_Addr_B(r_addr_b), .R_Data_B(rdb0),
    .wr_collision(coll0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // sel: 0/1 bypass R_Data_A/B, 2/3 no-bypass R_Data_A/B, 4/5 ready, 6/7 wr_collision (byp/nobyp)
  task automatic push(input string tag, input int sel, input logic [DW-1:0] exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [DW-1:0] act;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0: act = rda1;
        1: act = rdb1;
        2: act = rda0;
        3: act = rdb0;
        4: act = DW'(rdy1);
        5: act = DW'(rdy0);
        6: act = DW'(coll1);
        default: act = DW'(coll0);
      endcase
      chk(e.tag, act, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 0; w_en_a = 0; w_en_b = 0;
    w_addr_a = '0; w_addr_b = '0; w_data_a = '0; w_data_b = '0;
  endtask

  // Clear/init sequence: ready must rise exactly on the 32nd posedge.
  task automatic run_clear(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      push({tag, "_rdy"}, 4, DW'(i == DEPTH));
      push({tag, "_rdy0"}, 5, DW'(i == DEPTH));
      if (i < DEPTH) push({tag, "_rd_init"}, 0, '0);
      drain();
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      r_addr_a = AW'(a);
      r_addr_b = AW'(DEPTH - 1 - a);
      push({tag, "_a"}, 0, '0);
      push({tag, "_b"}, 1, '0);
      push({tag, "_a0"}, 2, '0);
      push({tag, "_b0"}, 3, '0);
      drain();
    end
  endtask

  logic [DW-1:0] fill [DEPTH];

  initial begin
    reset = 0;
    idle_inputs();
    r_addr_a = '0; r_addr_b = '0;
    step(); step();
    push("rst_ready", 4, '0);
    push("rst_coll", 6, '0);
    push("rst_rd", 0, '0);
    drain();

    // Release reset, hammer writes during INIT: they must not land.
    reset = 1;
    w_en_a = 1; w_addr_a = 5'd3; w_data_a = 32'hDEAD_BEEF;
    w_en_b = 1; w_addr_b = 5'd4; w_data_b = 32'hCAFE_F00D;
    r_addr_a = 5'd3;
    run_clear("init");
    idle_inputs();
    read_all_zero("post_init");

    // Single write with and without bypass.
    w_en_a = 1; w_addr_a = 5'd5; w_data_a = 32'h1234_5678; r_addr_a = 5'd5;
    push("byp_same", 0, 32'h1234_5678);
    push("nobyp_same", 2, 32'h0);
    drain();
    step(); idle_inputs();
    push("byp_after", 0, 32'h1234_5678);
    push("nobyp_after", 2, 32'h1234_5678);
    push("coll_single", 6, '0);
    drain();

    // Same-address collision: port B wins, one-cycle pulse.
    w_en_a = 1; w_addr_a = 5'd9; w_data_a = 32'hAAAA_AAAA;
    w_en_b = 1; w_addr_b = 5'd9; w_data_b = 32'h5555_5555;
    r_addr_a = 5'd9; r_addr_b = 5'd9;
    push("coll_byp_a", 0, 32'h5555_5555);
    push("coll_byp_b", 1, 32'h5555_5555);
    drain();
    step(); idle_inputs();
    push("coll_pulse", 6, 1);
    push("coll_pulse0", 7, 1);
    push("coll_store", 0, 32'h5555_5555);
    push("coll_store0", 2, 32'h5555_5555);
    drain();
    step();
    push("coll_drop", 6, 0);
    drain();

    w_en_a = 1; w_addr_a = 5'd10; w_data_a = 32'h0000_0A0A;
    w_en_b = 1; w_addr_b = 5'd11; w_data_b = 32'h0000_0B0B;
    r_addr_a = 5'd10; r_addr_b = 5'd11;
    push("dual_byp_a", 0, 32'h0000_0A0A);
    push("dual_byp_b", 1, 32'h0000_0B0B);
    drain();
    step(); idle_inputs();
    push("dual_coll", 6, 0);
    push("dual_a", 2, 32'h0000_0A0A);
    push("dual_b", 3, 32'h0000_0B0B);
    drain();

    // Fill 1..31 two at a time, then read back.
    for (int a = 1; a < DEPTH; a++) fill[a] = $urandom() | 32'h1;
    for (int a = 1; a < DEPTH; a += 2) begin
      w_en_a = 1; w_addr_a = AW'(a); w_data_a = fill[a];
      w_en_b = (a + 1 < DEPTH); w_addr_b = AW'(a + 1);
      w_data_b = (a + 1 < DEPTH) ? fill[a + 1] : '0;
      step();
    end
    idle_inputs();
    for (int a = 1; a < DEPTH; a++) begin
      r_addr_a = AW'(a); r_addr_b = AW'(a);
      push("fill_rd", 2, fill[a]);
      push("fill_rd_b", 1, fill[a]);
      drain();
    end

    // Clear request with a concurrent write to entry 7.
    clr_req = 1; w_en_a = 1; w_addr_a = 5'd7; w_data_a = 32'h0000_0077;
    step(); idle_inputs();
    r_addr_a = 5'd7;
    push("clr_ready", 4, 0);
    drain();
    run_clear("clr");
    read_all_zero("post_clr");

    // Reset mid-clear at clr_cnt=10: clear restarts from entry 0.
    w_en_a = 1; w_addr_a = 5'd12; w_data_a = 32'h0000_0C0C;
    step(); idle_inputs();
    clr_req = 1;
    step(); clr_req = 0;
    for (int i = 0; i < 10; i++) step();
    reset = 0;
    push("midrst_ready", 4, 0);
    push("midrst_coll", 6, 0);
    drain();
    step();
    reset = 1;
    run_clear("midrst");
    r_addr_a = 5'd12;
    push("midrst_rd", 0, 0);
    push("midrst_rd0", 2, 0);
    drain();

    // Entry 0 behaviour depends on ZERO_REG_EN.
    w_en_a = 1; w_addr_a = 5'd0; w_data_a = 32'hFFFF_FFFF; r_addr_a = 5'd0;
    push("zero_same", 0, ZR ? 32'h0 : 32'hFFFF_FFFF);
    push("zero_same0", 2, 32'h0);
    drain();
    step(); idle_inputs();
    push("zero_after", 0, ZR ? 32'h0 : 32'hFFFF_FFFF);
    push("zero_after0", 2, ZR ? 32'h0 : 32'hFFFF_FFFF);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised dual-write, dual-read register file for the next-generation datapath.
- Generalised in data width and depth (DEPTH = 2**ADDR_W).
- Adds a second write port with a defined collision priority, same-cycle write-to-read bypass, and a sequential clear engine, so that large arrays need no per-entry asynchronous reset.
- Sits between the decode stage (read addresses) and the writeback stage (write ports).

Parameters:
DATA_W, 32, width of every register entry and data port
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = reads return array contents only

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
clr_req  input  1  request a full clear of the array; sampled only in RUN
ready  output  1  1 = array usable (RUN); 0 = clear in progress
W_En_A  input  1  write enable, port A
W_Addr_A  input  ADDR_W  write address, port A
W_Data_A  input  DATA_W  write data, port A
W_En_B  input  1  write enable, port B
W_Addr_B  input  ADDR_W  write address, port B
W_Data_B  input  DATA_W  write data, port B
R_Addr_A  input  ADDR_W  read address A
R_Data_A  output  DATA_W  read data A (combinational)
R_Addr_B  input  ADDR_W  read address B
R_Data_B  output  DATA_W  read data B (combinational)
wr_collision  output  1  registered one-cycle pulse: both ports wrote the same address in the previous cycle

Behaviour:
- Storage array has no reset. Only the FSM, clear counter, ready and wr_collision are reset.
- Reset asserted (reset=0): state=INIT, clr_cnt=0, ready=0, wr_collision=0, asynchronously.
- FSM state INIT:
  - Each posedge writes 0 to entry clr_cnt, then clr_cnt++.
  - On the posedge that clears entry DEPTH-1, state becomes RUN and ready=1.
  - ready therefore rises after exactly DEPTH posedges following reset release.
  - W_En_A/B and clr_req are ignored; R_Data_A/B are forced to 0.
- FSM state RUN:
  - Writes occur on posedge when W_En_x=1.
  - Both ports enabled with W_Addr_A==W_Addr_B: port B data is stored, and wr_collision=1 on the next cycle.
  - wr_collision is 0 in every other cycle.
  - clr_req=1 on a posedge: that cycle's writes are discarded, state becomes INIT, clr_cnt=0, ready=0 on the same edge.
- Read path (RUN, BYPASS=1), priority order:
  - R_Addr matches an enabled port B write: return W_Data_B.
  - Otherwise, matches an enabled port A write: return W_Data_A.
  - Otherwise return the array entry.
- Read path (RUN, BYPASS=0): array contents only; a new value is visible on the cycle after its write edge.
- Reset assertion mid-clear or mid-write: the clear restarts from entry 0. Entries not yet cleared hold undefined data but stay unreadable until ready=1.
- clr_cnt is ADDR_W bits wide. Terminal detection is clr_cnt == DEPTH-1; no wrap beyond it.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired zero: reads of address 0 return 0 regardless of bypass.
  - Writes to address 0 are dropped.
  - A same-address collision at address 0 still pulses wr_collision.
- Undefined: entry 0 is an ordinary register.

Test Plan:
- Reset released, DEPTH=32 -> ready=0 for 32 posedges then 1; every read returns 0; writes issued during INIT have no effect.
- RUN: A writes 0x1234_5678 to addr 5 -> with BYPASS=1, R_Data_A(addr 5)=0x1234_5678 in the same cycle and after the edge. With BYPASS=0, the value appears only after the edge.
- Both ports write addr 9 (A=0xAAAA_AAAA, B=0x5555_5555) -> stored 0x5555_5555; wr_collision=1 for exactly one cycle; different addresses give wr_collision=0.
- Fill entries 1..31 with nonzero data, pulse clr_req with a concurrent write -> ready=0 for 32 cycles; afterwards all entries read 0, including the concurrently written one.
- Assert reset at clr_cnt=10 during INIT -> ready stays 0; after release, 32 more posedges pass before ready=1.
- ZERO_REG_EN defined: write 0xFFFF_FFFF to addr 0 -> R_Data_A(addr 0)=0 in the same cycle and afterwards. Undefined: reads back 0xFFFF_FFFF.
